// File: rtl/mem_bus_pkg.sv
// Shared encodings for the data-memory arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } arb_state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_e;

  localparam int LOADER_PORT = 0;
  localparam int CPU_PORT    = 1;

endpackage

// File: rtl/arb_pick.sv
// One-hot winner select from the eligible vector.
// MEM_ARB_RR_EN: round-robin search from i_ptr; otherwise lowest index wins.
module arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_elig,
`ifdef MEM_ARB_RR_EN
  input  logic [PTR_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_gnt
);

`ifdef MEM_ARB_RR_EN
  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_elig[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
`else
  // isolate the lowest set bit
  assign o_gnt = i_elig & (~i_elig + NUM_REQ'(1));
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Sequences NUM_REQ requesters onto the byte-wide memory handshake.
// MEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    boot_done,
  input  logic [NUM_REQ-1:0]      req_rd,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [7:0]              rdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_data_in,
  input  logic [7:0]              mem_data_out,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  input  logic                    mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e          r_state;
  mem_op_e             r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_err;
  logic [7:0]          r_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic                r_rd_en;
  logic                r_wr_en;

  logic [NUM_REQ-1:0]  w_mask;
  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [7:0]          w_sel_data;
  logic                w_sel_wr;

  always_comb begin
    w_mask              = '0;
    w_mask[LOADER_PORT] = 1'b1;
    if (boot_done) w_mask = '1;
  end

  assign w_elig = (req_rd | req_wr) & w_mask;

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win_idx;
  logic [PTR_W-1:0] w_ptr_nxt;

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt[i]) w_win_idx = PTR_W'(i);
  end

  assign w_ptr_nxt = (w_win_idx == PTR_W'(NUM_REQ-1)) ?
                     '0 : w_win_idx + 1'b1;

  arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt)
  );
`else
  arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_elig (w_elig),
    .o_gnt  (w_gnt)
  );
`endif

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_wr   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_wdata[i*8 +: 8];
        w_sel_wr   = req_wr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_RD;
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_grant <= w_gnt;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_data;
            r_op    <= w_sel_wr ? OP_WR : OP_RD;
            r_state <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
            r_ptr   <= w_ptr_nxt;
`endif
          end
        end
        S_ISSUE: begin
          r_rd_en <= (r_op == OP_RD);
          r_wr_en <= (r_op == OP_WR);
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (r_op == OP_RD) r_rdata <= mem_data_out;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_err   <= r_grant;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant        = r_grant;
  assign req_done     = r_done;
  assign req_err      = r_err;
  assign rdata        = r_rdata;
  assign mem_addr     = r_addr;
  assign mem_data_in  = r_wdata;
  assign mem_read_en  = r_rd_en;
  assign mem_write_en = r_wr_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a queue scoreboard and memory model.
module tb_mem_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          boot_done;
  logic [NR-1:0] req_rd;
  logic [NR-1:0] req_wr;
  logic [NR*AW-1:0] req_addr;
  logic [NR*8-1:0]  req_wdata;
  logic [NR-1:0] req_done;
  logic [NR-1:0] req_err;
  logic [7:0]    rdata;
  logic [NR-1:0] grant;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data_in;
  logic [7:0]    mem_data_out;
  logic          mem_read_en;
  logic          mem_write_en;
  logic          mem_ready;

  mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .boot_done    (boot_done),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_done     (req_done),
    .req_err      (req_err),
    .rdata        (rdata),
    .grant        (grant),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       port;
    bit       is_err;
    bit       is_rd;
    bit [7:0] data;
  } exp_t;

  exp_t     sb[$];
  int       n_chk = 0;
  int       n_err = 0;
  int       remaining[NR];
  int       cyc = 0;
  int       rise_cyc = 0;
  bit       prev_stb = 1'b0;
  bit       prev_pulse = 1'b0;
  bit       saw_rd = 1'b0;
  bit       saw_wr = 1'b0;
  int       mem_mode = 0;
  bit       resp = 1'b0;
  bit [7:0] mem[256];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int p, bit rd, bit wr, bit [AW-1:0] a,
                         bit [7:0] d, int n);
    req_rd[p] = rd;
    req_wr[p] = wr;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*8 +: 8] = d;
    remaining[p] = n;
  endtask

  task automatic push(int p, bit e, bit rd, bit [7:0] d);
    exp_t x;
    x.port = p; x.is_err = e; x.is_rd = rd; x.data = d;
    sb.push_back(x);
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((sb.size() != 0 || remaining[0] != 0 || remaining[1] != 0)
           && n < lim) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain", sb.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    bit   stb;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      stb = mem_read_en | mem_write_en;
      if (rst_n) begin
        if (stb && !prev_stb) rise_cyc = cyc;
        if (mem_read_en) saw_rd = 1'b1;
        if (mem_write_en) saw_wr = 1'b1;
        if (stb) check("strobe_excl", mem_read_en & mem_write_en, 0);
        if (prev_pulse) check("gap", stb, 0);
        for (int p = 0; p < NR; p++) begin
          if (req_done[p] || req_err[p]) begin
            if (sb.size() == 0) begin
              check("unexpected", {req_done[p], req_err[p]}, 0);
            end else begin
              e = sb.pop_front();
              check("port", p, e.port);
              check("kind", req_err[p], e.is_err);
              if (e.is_err) check("to_lat", cyc - rise_cyc, TO);
              else if (e.is_rd) check("rdata", rdata, e.data);
            end
            if (remaining[p] > 0) remaining[p]--;
            if (remaining[p] == 0) begin
              req_rd[p] = 1'b0;
              req_wr[p] = 1'b0;
            end
          end
        end
        prev_pulse = (|req_done) | (|req_err);
      end else begin
        prev_pulse = 1'b0;
      end
      prev_stb = stb;
    end
  endtask

  task automatic memory();
    forever begin
      @(posedge clk);
      mem_ready <= 1'b0;
      if (!(mem_read_en | mem_write_en)) begin
        resp = 1'b0;
      end else if (!resp && mem_mode == 0) begin
        resp = 1'b1;
        mem_ready <= 1'b1;
        if (mem_write_en) mem[mem_addr[7:0]] = mem_data_in;
        else mem_data_out <= mem[mem_addr[7:0]];
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    boot_done = 1'b1;
    req_rd = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    mem_data_out = '0;
    remaining[0] = 0;
    remaining[1] = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'hAB] = 8'h1E;
    mem[8'h30] = 8'hC3;
    mem[8'h31] = 8'h3C;
    mem[8'h40] = 8'h99;
    fork
      monitor();
      memory();
    join_none

    repeat (3) @(posedge clk);
    #2;
    check("rst_grant", grant, 0);
    check("rst_done", req_done, 0);
    check("rst_err", req_err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rden", mem_read_en, 0);
    check("rst_wren", mem_write_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read with cycle-exact timing
    @(negedge clk);
    set_req(1, 1, 0, 32'hAB, 8'h00, 1);
    push(1, 0, 1, 8'h1E);
    @(posedge clk); #2;
    check("c1_grant", grant, 2'b10);
    check("c1_rden", mem_read_en, 0);
    @(posedge clk); #2;
    check("c2_rden", mem_read_en, 1);
    check("c2_addr", mem_addr, 32'hAB);
    @(posedge clk); #2;
    check("c3_done", req_done, 0);
    @(posedge clk); #2;
    check("c4_done", req_done, 2'b10);
    check("c4_rdata", rdata, 8'h1E);
    drain(20);
    check("rdata_hold", rdata, 8'h1E);

    // rd+wr together is a write
    @(negedge clk);
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    set_req(1, 1, 1, 32'h20, 8'h7F, 1);
    push(1, 0, 0, 8'h00);
    drain(30);
    check("rdwr_no_rd", saw_rd, 0);
    check("rdwr_wr", saw_wr, 1);
    @(negedge clk);
    set_req(1, 1, 0, 32'h20, 8'h00, 1);
    push(1, 0, 1, 8'h7F);
    drain(30);

    // boot gating
    @(negedge clk);
    boot_done = 1'b0;
    set_req(1, 1, 0, 32'h40, 8'h00, 1);
    set_req(0, 0, 1, 32'h10, 8'h55, 1);
    push(0, 0, 0, 8'h00);
    push(1, 0, 1, 8'h99);
    n = 0;
    while (sb.size() > 1 && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    #2;
    check("boot_pending", sb.size(), 1);
    check("boot_grant", grant, 0);
    check("boot_rdhold", req_rd[1], 1);
    @(negedge clk);
    boot_done = 1'b1;
    drain(30);
    @(negedge clk);
    set_req(0, 1, 0, 32'h10, 8'h00, 1);
    push(0, 0, 1, 8'h55);
    drain(30);

    // contention: both ports request continuously
    @(negedge clk);
    set_req(0, 1, 0, 32'h30, 8'h00, 3);
    set_req(1, 1, 0, 32'h31, 8'h00, 3);
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      push(0, 0, 1, 8'hC3);
      push(1, 0, 1, 8'h3C);
    end
`else
    for (int k = 0; k < 3; k++) push(0, 0, 1, 8'hC3);
    for (int k = 0; k < 3; k++) push(1, 0, 1, 8'h3C);
`endif
    drain(100);

    // timeout
    @(negedge clk);
    mem_mode = 1;
    set_req(1, 1, 0, 32'h50, 8'h00, 1);
    push(1, 1, 0, 8'h00);
    drain(200);
    check("to_rden", mem_read_en, 0);
    check("to_grant", grant, 0);

    // async reset during WAIT
    @(negedge clk);
    set_req(1, 1, 0, 32'h60, 8'h00, 1);
    n = 0;
    while (!mem_read_en && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("ar_strobe", mem_read_en, 1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_rden", mem_read_en, 0);
    check("ar_grant", grant, 0);
    check("ar_done", req_done, 0);
    set_req(1, 0, 0, 32'h0, 8'h00, 0);
    mem_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(1, 1, 0, 32'h20, 8'h00, 1);
    push(1, 0, 1, 8'h7F);
    drain(30);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
